// File: rtl/cache_pkg.sv
// Shared definitions for the two-way write-back cache.
// Holds the default parameter values, the FSM state encodings and helper
// functions that split a CPU word address into offset, index and tag fields.
package cache_pkg;

  localparam int unsigned DefAddrW  = 12;
  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefWpl    = 4;
  localparam int unsigned DefSets   = 4;
  localparam int unsigned DefMemLat = 6;

  // Controller states.
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWbReq    = 3'd1;
  localparam logic [2:0] StWbWait   = 3'd2;
  localparam logic [2:0] StFillReq  = 3'd3;
  localparam logic [2:0] StFillWait = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;

  function automatic int unsigned off_w(int unsigned wpl);
    return $clog2(wpl);
  endfunction

  function automatic int unsigned idx_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(int unsigned addr_w, int unsigned wpl,
                                        int unsigned sets);
    return addr_w - off_w(wpl) - idx_w(sets);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set tag, line data, valid and dirty bits.
// Ports:
//   CLK, RSTn           clock, synchronous active-low reset (clears valid/dirty)
//   idx, tag            set index and tag for lookup; tag is also the fill tag
//   hit                 valid and tag match at idx
//   valid, dirty        state bits of the line at idx
//   line_tag, line      stored tag and data of the line at idx
//   wr_en/wr_off/wr_data  single-word write into the line at idx, sets dirty
//   fill_en/fill_line   whole-line load at idx, marks valid and clean
module cache_way
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned WPL    = DefWpl,
  parameter int unsigned SETS   = DefSets
) (
  input  logic                                 CLK,
  input  logic                                 RSTn,
  input  logic [idx_w(SETS)-1:0]               idx,
  input  logic [tag_w(ADDR_W, WPL, SETS)-1:0]  tag,
  output logic                                 hit,
  output logic                                 valid,
  output logic                                 dirty,
  output logic [tag_w(ADDR_W, WPL, SETS)-1:0]  line_tag,
  output logic [DATA_W*WPL-1:0]                line,
  input  logic                                 wr_en,
  input  logic [off_w(WPL)-1:0]                wr_off,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic                                 fill_en,
  input  logic [DATA_W*WPL-1:0]                fill_line
);
  localparam int unsigned TagW = tag_w(ADDR_W, WPL, SETS);

  logic [TagW-1:0]               tag_q   [SETS];
  logic [WPL-1:0][DATA_W-1:0]    data_q  [SETS];
  logic [SETS-1:0]               valid_q;
  logic [SETS-1:0]               dirty_q;

  assign valid    = valid_q[idx];
  assign dirty    = dirty_q[idx];
  assign line_tag = tag_q[idx];
  assign line     = data_q[idx];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      data_q[idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_wb2.sv
// Two-way set-associative, write-back, write-allocate cache.
// Ports:
//   CLK, RSTn                 clock, synchronous active-low reset
//   MemRead, MemWrite         CPU request (write wins when both are set)
//   CPU_MEM_ADDR_IN/DI/DOUT   CPU word address, write data, read data
//   READY                     request complete (or idle); low while a miss is serviced
//   D_MEM_DI / D_MEM_DOUT     fill line from / write-back line to DMEM
//   D_MEM_ADDR                DMEM line address
//   D_MEM_CSN, D_MEM_WEN      active-low DMEM select and write enable
module cache_wb2
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned WPL     = DefWpl,
  parameter int unsigned SETS    = DefSets,
  parameter int unsigned MEM_LAT = DefMemLat
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          MemRead,
  input  logic                          MemWrite,
  input  logic [ADDR_W-1:0]             CPU_MEM_ADDR_IN,
  input  logic [DATA_W-1:0]             CPU_MEM_DI,
  output logic [DATA_W-1:0]             CPU_MEM_DOUT,
  output logic                          READY,
  input  logic [DATA_W*WPL-1:0]         D_MEM_DI,
  output logic [DATA_W*WPL-1:0]         D_MEM_DOUT,
  output logic [ADDR_W-off_w(WPL)-1:0]  D_MEM_ADDR,
  output logic                          D_MEM_CSN,
  output logic                          D_MEM_WEN
);
  localparam int unsigned OffW = off_w(WPL);
  localparam int unsigned IdxW = idx_w(SETS);
  localparam int unsigned TagW = tag_w(ADDR_W, WPL, SETS);
  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT);

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SETS-1:0]   lru_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              victim_q, victim;
  logic              latch, lru_set, lru_val;

  logic [OffW-1:0] cpu_off, lat_off, wr_off;
  logic [IdxW-1:0] cpu_idx, lat_idx, cur_idx;
  logic [TagW-1:0] cpu_tag, lat_tag, cur_tag;
  logic [DATA_W-1:0] wr_data;

  logic [1:0] hit, valid, dirty, wr_en, fill_en;
  logic              hit_way;
  logic [TagW-1:0]             way_tag  [2];
  logic [WPL-1:0][DATA_W-1:0]  way_line [2];

  assign cpu_off = CPU_MEM_ADDR_IN[OffW-1:0];
  assign cpu_idx = CPU_MEM_ADDR_IN[OffW +: IdxW];
  assign cpu_tag = CPU_MEM_ADDR_IN[ADDR_W-1 -: TagW];
  assign lat_off = addr_q[OffW-1:0];
  assign lat_idx = addr_q[OffW +: IdxW];
  assign lat_tag = addr_q[ADDR_W-1 -: TagW];

  // Live CPU address in IDLE; the latched request everywhere else, so a CPU
  // changing its inputs mid-miss has no effect.
  assign cur_idx = (state_q == StIdle) ? cpu_idx : lat_idx;
  assign cur_tag = (state_q == StIdle) ? cpu_tag : lat_tag;
  assign hit_way = !hit[0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WPL    (WPL),
      .SETS   (SETS)
    ) u_way (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .idx       (cur_idx),
      .tag       (cur_tag),
      .hit       (hit[w]),
      .valid     (valid[w]),
      .dirty     (dirty[w]),
      .line_tag  (way_tag[w]),
      .line      (way_line[w]),
      .wr_en     (wr_en[w]),
      .wr_off    (wr_off),
      .wr_data   (wr_data),
      .fill_en   (fill_en[w]),
      .fill_line (D_MEM_DI)
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    READY        = 1'b0;
    CPU_MEM_DOUT = '0;
    D_MEM_CSN    = 1'b1;
    D_MEM_WEN    = 1'b1;
    D_MEM_ADDR   = '0;
    D_MEM_DOUT   = '0;
    wr_en        = 2'b00;
    fill_en      = 2'b00;
    wr_off       = cpu_off;
    wr_data      = CPU_MEM_DI;
    lru_set      = 1'b0;
    lru_val      = 1'b0;
    latch        = 1'b0;
    victim       = 1'b0;

    unique case (state_q)
      StIdle: begin
        READY = 1'b1;
        if (MemRead || MemWrite) begin
          if (|hit) begin
            if (MemWrite) wr_en[hit_way] = 1'b1;
            else          CPU_MEM_DOUT   = way_line[hit_way][cpu_off];
            lru_set = 1'b1;
            lru_val = ~hit_way;
          end else begin
            READY = 1'b0;
            latch = 1'b1;
            if (!valid[0])      victim = 1'b0;
            else if (!valid[1]) victim = 1'b1;
            else                victim = lru_q[cpu_idx];
            state_d = (valid[victim] && dirty[victim]) ? StWbReq : StFillReq;
          end
        end
      end
      StWbReq: begin
        D_MEM_CSN  = 1'b0;
        D_MEM_WEN  = 1'b0;
        D_MEM_ADDR = {way_tag[victim_q], lat_idx};
        D_MEM_DOUT = way_line[victim_q];
        cnt_d      = CntW'(1);
        state_d    = StWbWait;
      end
      StWbWait: begin
        if (cnt_q == CntLast) state_d = StFillReq;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StFillReq: begin
        D_MEM_CSN  = 1'b0;
        D_MEM_ADDR = {lat_tag, lat_idx};
        cnt_d      = CntW'(1);
        state_d    = StFillWait;
      end
      StFillWait: begin
        if (cnt_q == CntLast) begin
          fill_en[victim_q] = 1'b1;
          state_d           = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        READY = 1'b1;
        if (wr_q) begin
          wr_en[victim_q] = 1'b1;
          wr_off          = lat_off;
          wr_data         = wdata_q;
        end else begin
          CPU_MEM_DOUT = way_line[victim_q][lat_off];
        end
        lru_set = 1'b1;
        lru_val = ~victim_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lru_set) lru_q[cur_idx] <= lru_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (latch) begin
      addr_q   <= CPU_MEM_ADDR_IN;
      wdata_q  <= CPU_MEM_DI;
      wr_q     <= MemWrite;
      victim_q <= victim;
    end
  end

endmodule

// File: tb/tb_cache_wb2.sv
// Self-checking bench for cache_wb2 with a behavioural DMEM and a word-level
// reference memory; expected read data is queued when a request is issued.
module tb_cache_wb2;
  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned WPL = 4;
  localparam int unsigned LW  = DW * WPL;
  localparam int unsigned MAW = AW - 2;

  logic           CLK = 1'b0;
  logic           RSTn = 1'b0;
  logic           MemRead = 1'b0;
  logic           MemWrite = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [DW-1:0]  di = '0;
  logic [DW-1:0]  dout;
  logic           ready;
  logic [LW-1:0]  mem_di = '0;
  logic [LW-1:0]  mem_dout;
  logic [MAW-1:0] mem_addr;
  logic           csn, wen;

  cache_wb2 dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .CPU_MEM_ADDR_IN (addr),
    .CPU_MEM_DI      (di),
    .CPU_MEM_DOUT    (dout),
    .READY           (ready),
    .D_MEM_DI        (mem_di),
    .D_MEM_DOUT      (mem_dout),
    .D_MEM_ADDR      (mem_addr),
    .D_MEM_CSN       (csn),
    .D_MEM_WEN       (wen)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]  ref_mem [1 << AW];
  logic [LW-1:0]  mem     [1 << MAW];
  logic [DW-1:0]  exp_q   [$];

  int             fill_cnt = 0;
  int             wb_cnt   = 0;
  logic [MAW-1:0] fill_addr = '0;
  logic [MAW-1:0] wb_addr   = '0;
  logic [LW-1:0]  wb_line   = '0;

  // DMEM model: strobes are sampled mid-cycle; fill data is presented from
  // the request cycle onward and held until the next request.
  always @(negedge CLK) begin
    if (csn === 1'b0) begin
      if (wen === 1'b0) begin
        wb_cnt++;
        wb_addr = mem_addr;
        wb_line = mem_dout;
        mem[mem_addr] = mem_dout;
      end else begin
        fill_cnt++;
        fill_addr = mem_addr;
        mem_di = mem[mem_addr];
      end
    end
  end

  // Issue one CPU request and hold it until READY; lat = -1 on timeout.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rdata,
                        output int nfill, output int nwb);
    int f0, w0;
    f0 = fill_cnt;
    w0 = wb_cnt;
    @(posedge CLK);
    #1;
    MemRead = rd;
    MemWrite = wr;
    addr = a;
    di = d;
    lat = 0;
    @(negedge CLK);
    while (ready !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge CLK);
    end
    if (ready !== 1'b1) lat = -1;
    rdata = dout;
    nfill = fill_cnt - f0;
    nwb = wb_cnt - w0;
    @(posedge CLK);
    #1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(negedge CLK);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (csn !== 1'b1) begin bad++; $display("FAIL reset_csn got=%b want=1", csn); end
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL reset_wen got=%b want=1", wen); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_maddr got=%h want=0", mem_addr); end
    total++; if (mem_dout !== '0) begin bad++; $display("FAIL reset_mdout got=%h want=0", mem_dout); end
    // Idle with no request: no DMEM activity.
    repeat (4) @(negedge CLK);
    total++; if (fill_cnt != 0 || wb_cnt != 0) begin
      bad++; $display("FAIL idle_strobes fills=%0d wbs=%0d want 0/0", fill_cnt, wb_cnt);
    end
  endtask

  task automatic test_miss_fill();
    int lat, nf, nw;
    logic [DW-1:0] rd, exp;
    exp_q.push_back(ref_mem[12'h010]);
    access(1'b1, 1'b0, 12'h010, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 8) begin bad++; $display("FAIL miss_fill_lat got=%0d want=8", lat); end
    total++; if (nf != 1 || nw != 0) begin
      bad++; $display("FAIL miss_fill_strobes fills=%0d wbs=%0d want 1/0", nf, nw);
    end
    total++; if (fill_addr !== 10'h004) begin
      bad++; $display("FAIL miss_fill_addr got=%h want=004", fill_addr);
    end
    total++; if (rd !== exp) begin bad++; $display("FAIL miss_fill_data got=%h want=%h", rd, exp); end
  endtask

  task automatic test_hit_read();
    int lat, nf, nw;
    logic [DW-1:0] rd, exp;
    exp_q.push_back(ref_mem[12'h010]);
    access(1'b1, 1'b0, 12'h010, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 0) begin bad++; $display("FAIL hit_read_lat got=%0d want=0", lat); end
    total++; if (nf != 0 || nw != 0) begin
      bad++; $display("FAIL hit_read_strobes fills=%0d wbs=%0d want 0/0", nf, nw);
    end
    total++; if (rd !== exp) begin bad++; $display("FAIL hit_read_data got=%h want=%h", rd, exp); end
  endtask

  task automatic test_write_hit();
    int lat, nf, nw;
    logic [DW-1:0] rd, exp;
    ref_mem[12'h011] = 32'hDEADBEEF;
    access(1'b0, 1'b1, 12'h011, 32'hDEADBEEF, lat, rd, nf, nw);
    total++; if (lat != 0 || nf != 0 || nw != 0) begin
      bad++; $display("FAIL write_hit lat=%0d fills=%0d wbs=%0d want 0/0/0", lat, nf, nw);
    end
    exp_q.push_back(ref_mem[12'h011]);
    access(1'b1, 1'b0, 12'h011, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (rd !== exp || lat != 0) begin
      bad++; $display("FAIL write_hit_readback got=%h lat=%0d want=%h lat=0", rd, lat, exp);
    end
    // Read and write together: the write must win.
    ref_mem[12'h012] = 32'hCAFEF00D;
    access(1'b1, 1'b1, 12'h012, 32'hCAFEF00D, lat, rd, nf, nw);
    total++; if (lat != 0 || nf != 0 || nw != 0) begin
      bad++; $display("FAIL rw_both lat=%0d fills=%0d wbs=%0d want 0/0/0", lat, nf, nw);
    end
    exp_q.push_back(ref_mem[12'h012]);
    access(1'b1, 1'b0, 12'h012, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (rd !== exp) begin bad++; $display("FAIL rw_both_readback got=%h want=%h", rd, exp); end
  endtask

  task automatic test_evict();
    int lat, nf, nw;
    logic [DW-1:0] rd, exp;
    logic [LW-1:0] line;
    exp_q.push_back(ref_mem[12'h000]);
    access(1'b1, 1'b0, 12'h000, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 8 || nf != 1 || nw != 0) begin
      bad++; $display("FAIL evict_fill0 lat=%0d fills=%0d wbs=%0d want 8/1/0", lat, nf, nw);
    end
    total++; if (rd !== exp) begin bad++; $display("FAIL evict_fill0_data got=%h want=%h", rd, exp); end
    exp_q.push_back(ref_mem[12'h020]);
    access(1'b1, 1'b0, 12'h020, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    line = wb_line;
    total++; if (lat != 15) begin bad++; $display("FAIL evict_wb_lat got=%0d want=15", lat); end
    total++; if (nf != 1 || nw != 1) begin
      bad++; $display("FAIL evict_wb_strobes fills=%0d wbs=%0d want 1/1", nf, nw);
    end
    total++; if (wb_addr !== 10'h004) begin
      bad++; $display("FAIL evict_wb_addr got=%h want=004", wb_addr);
    end
    total++; if (line[63:32] !== 32'hDEADBEEF || line[95:64] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL evict_wb_line got=%h want words1/2=DEADBEEF/CAFEF00D", line);
    end
    total++; if (fill_addr !== 10'h008) begin
      bad++; $display("FAIL evict_fill_addr got=%h want=008", fill_addr);
    end
    total++; if (rd !== exp) begin bad++; $display("FAIL evict_data got=%h want=%h", rd, exp); end
  endtask

  task automatic test_write_miss();
    int lat, nf, nw;
    logic [DW-1:0] rd, exp;
    ref_mem[12'h035] = 32'h12345678;
    access(1'b0, 1'b1, 12'h035, 32'h12345678, lat, rd, nf, nw);
    total++; if (lat != 8 || nf != 1 || nw != 0) begin
      bad++; $display("FAIL wmiss lat=%0d fills=%0d wbs=%0d want 8/1/0", lat, nf, nw);
    end
    exp_q.push_back(ref_mem[12'h035]);
    access(1'b1, 1'b0, 12'h035, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (rd !== exp || lat != 0) begin
      bad++; $display("FAIL wmiss_merge got=%h lat=%0d want=%h lat=0", rd, lat, exp);
    end
    exp_q.push_back(ref_mem[12'h005]);
    access(1'b1, 1'b0, 12'h005, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 8 || nw != 0 || rd !== exp) begin
      bad++; $display("FAIL wmiss_other lat=%0d wbs=%0d data=%h want 8/0/%h", lat, nw, rd, exp);
    end
    exp_q.push_back(ref_mem[12'h015]);
    access(1'b1, 1'b0, 12'h015, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 15 || nw != 1 || wb_addr !== 10'h00D) begin
      bad++; $display("FAIL wmiss_evict lat=%0d wbs=%0d addr=%h want 15/1/00D", lat, nw, wb_addr);
    end
    total++; if (wb_line[63:32] !== 32'h12345678 || rd !== exp) begin
      bad++; $display("FAIL wmiss_wb_data word1=%h data=%h want 12345678/%h",
                      wb_line[63:32], rd, exp);
    end
    // Reloaded from DMEM: the merged word must have survived the write-back.
    exp_q.push_back(ref_mem[12'h035]);
    access(1'b1, 1'b0, 12'h035, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 8 || nw != 0 || rd !== exp) begin
      bad++; $display("FAIL wmiss_reload lat=%0d wbs=%0d data=%h want 8/0/%h", lat, nw, rd, exp);
    end
  endtask

  task automatic test_reset_mid_miss();
    int f0, w0, n, lat, nf, nw;
    logic [DW-1:0] rd, exp;
    f0 = fill_cnt;
    w0 = wb_cnt;
    @(posedge CLK);
    #1;
    MemRead = 1'b1;
    addr = 12'h040;
    n = 0;
    @(negedge CLK);
    while (fill_cnt == f0 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    total++; if (fill_cnt == f0) begin
      bad++; $display("FAIL midreset_no_fill fills=%0d want %0d", fill_cnt, f0 + 1);
    end
    @(posedge CLK);
    #1;
    RSTn = 1'b0;
    MemRead = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(negedge CLK);
    total++; if (ready !== 1'b1 || csn !== 1'b1) begin
      bad++; $display("FAIL midreset_outputs ready=%b csn=%b want 1/1", ready, csn);
    end
    repeat (10) @(negedge CLK);
    total++; if (fill_cnt != f0 + 1 || wb_cnt != w0) begin
      bad++; $display("FAIL midreset_strobes fills=%0d wbs=%0d want %0d/%0d",
                      fill_cnt - f0, wb_cnt - w0, 1, 0);
    end
    exp_q.push_back(ref_mem[12'h040]);
    access(1'b1, 1'b0, 12'h040, '0, lat, rd, nf, nw);
    exp = exp_q.pop_front();
    total++; if (lat != 8 || nf != 1 || rd !== exp) begin
      bad++; $display("FAIL midreset_reread lat=%0d fills=%0d data=%h want 8/1/%h",
                      lat, nf, rd, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h5A00_0000 | i;
    for (int l = 0; l < (1 << MAW); l++) begin
      for (int w = 0; w < WPL; w++) mem[l][w*DW +: DW] = 32'h5A00_0000 | (l * WPL + w);
    end
    test_reset();
    test_miss_fill();
    test_hit_read();
    test_write_hit();
    test_evict();
    test_write_miss();
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_wb2.md
CACHE_WB2 -- requirements
Module: cache_wb2

Interface
REQ-001 Parameter ADDR_W, default 12, sets CPU word-address width.
REQ-002 Parameter DATA_W, default 32, sets CPU word width.
REQ-003 Parameter WPL, default 4, sets words per line (power of 2, >=2).
REQ-004 Parameter SETS, default 4, sets the number of sets (power of 2, >=2); the block has 2 ways per set.
REQ-005 Parameter MEM_LAT, default 6, sets the DMEM access latency in cycles (>=1).
REQ-006 Clocking SHALL be: CLK, in, 1, clock, rising edge only; RSTn, in, 1, reset, synchronous, active-low.
REQ-007 MemRead, in, 1, CPU read request.
REQ-008 MemWrite, in, 1, CPU write request.
REQ-009 CPU_MEM_ADDR_IN, in, ADDR_W, word address; the fields SHALL be off = [OFF-1:0], idx = next IDX bits, tag = remainder, with OFF = log2(WPL) and IDX = log2(SETS).
REQ-010 CPU_MEM_DI, in, DATA_W, write data.
REQ-011 CPU_MEM_DOUT, out, DATA_W, read data, valid when READY=1 for a read.
REQ-012 READY, out, 1, request complete or idle; this port replaces the WriteAll stall signal.
REQ-013 D_MEM_DI, in, DATA_W*WPL, fill line from DMEM.
REQ-014 D_MEM_DOUT, out, DATA_W*WPL, write-back line.
REQ-015 D_MEM_ADDR, out, ADDR_W-OFF, line address.
REQ-016 D_MEM_CSN, out, 1, active-low DMEM select.
REQ-017 D_MEM_WEN, out, 1, active-low DMEM write enable.

Function
REQ-018 The block SHALL be a 2-way set-associative, write-back, write-allocate cache with per-line valid and dirty bits and 1 LRU bit per set.
REQ-019 A hit (valid and tag match in either way) SHALL assert READY combinationally in the same cycle; read data SHALL appear on CPU_MEM_DOUT that cycle.
REQ-020 A write hit SHALL update the selected word on the next rising edge and set the dirty bit; no DMEM access SHALL occur.
REQ-021 If MemRead and MemWrite are both high, the write SHALL take precedence.
REQ-022 The FSM SHALL have the states IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT and DONE.
REQ-023 On a miss in IDLE, READY SHALL be 0, and the block SHALL latch the address and write data and select a victim: the first invalid way (way0 first), otherwise the LRU way.
REQ-024 From IDLE on a miss, the next state SHALL be WB_REQ if the victim is valid and dirty, otherwise FILL_REQ.
REQ-025 In WB_REQ (1 cycle), the block SHALL drive CSN=0, WEN=0, ADDR={victim tag, idx} and DOUT=victim line; WB_WAIT SHALL then last MEM_LAT cycles with CSN=1, followed by FILL_REQ.
REQ-026 In FILL_REQ (1 cycle), the block SHALL drive CSN=0, WEN=1 and ADDR={tag, idx}; FILL_WAIT SHALL then last MEM_LAT cycles, and D_MEM_DI SHALL be captured into the victim way on its last cycle with valid=1, dirty=0 and the new tag.
REQ-027 In DONE (1 cycle), READY SHALL be 1 and the latched request SHALL complete as a hit: a read returns its word, and a write merges its word and sets dirty. The next state SHALL be IDLE.
REQ-028 Miss latency (READY low cycles) SHALL be MEM_LAT+2 for a clean fill and 2*MEM_LAT+3 with write-back.
REQ-029 Every hit and every DONE SHALL set the set's LRU bit to point at the other way.
REQ-030 The CPU SHALL hold its request while READY=0; input changes during a miss SHALL be ignored.
REQ-031 Outside the WB_REQ and FILL_REQ states, D_MEM_CSN and D_MEM_WEN SHALL be 1.
REQ-032 With no request in IDLE, READY SHALL be 1 and the block SHALL have no side effects.
REQ-033 The wait counter SHALL have width clog2(MEM_LAT+1) and SHALL NOT wrap.

Reset
REQ-034 While RSTn=0 at a rising edge, the block SHALL go to IDLE and clear all valid, dirty and LRU bits and the counter.
REQ-035 After reset, outputs SHALL be: READY=1, D_MEM_CSN=1, D_MEM_WEN=1, CPU_MEM_DOUT=0, D_MEM_ADDR=0, D_MEM_DOUT=0.
REQ-036 A reset mid-miss SHALL abandon the transaction; dirty data is lost and no further DMEM strobe is issued.
REQ-037 Tag and data arrays SHALL NOT require reset.

Structure
REQ-038 A shared package cache_pkg SHALL hold the FSM state enum, the default parameter constants and the field-width helper functions (OFF, IDX, TAG widths).
REQ-039 A sub-module cache_way SHALL implement one way: tag, data, valid and dirty arrays with lookup, word-write and line-fill ports; it SHALL be instantiated twice.

Verification
REQ-040 Defaults apply to all scenarios; after reset, read 0x010 SHALL keep READY low 8 cycles, issue one CSN pulse with WEN=1 and ADDR=0x004, then return the filled word.
REQ-041 Repeating the read of 0x010 SHALL assert READY the same cycle, with no CSN activity.
REQ-042 Writing 0xDEADBEEF to 0x011 (hit) SHALL produce no CSN; a subsequent read of 0x011 SHALL return 0xDEADBEEF.
REQ-043 After the 0x011 write, fills of 0x000 then 0x020 (index 0, 3 tags) SHALL evict dirty tag 1 with a write-back to ADDR=0x004 whose DOUT word1=0xDEADBEEF, and READY SHALL stay low 15 cycles.
REQ-044 A write miss to 0x035 SHALL fill the line, merge the word and leave the line dirty, with no WEN=0 strobe until its eviction.
REQ-045 Asserting RSTn=0 during FILL_WAIT SHALL return READY=1 and CSN=1 next cycle, and a re-read of the same address SHALL miss.
